aqed_result_monitor: RTL



---
 rtl/aqed_mon_pkg.sv | 21 ++
 rtl/aqed_sat_counter.sv | 40 ++++
 rtl/aqed_result_monitor.sv | 121 ++++++++++++
 3 files changed

// File: rtl/aqed_mon_pkg.sv
// Shared types and defaults for the A-QED result monitor.
// The state encoding is fixed at 3 bits so formal harnesses can probe it directly.
package aqed_mon_pkg;

  localparam int unsigned AQED_RESP_BOUND_DEFAULT = 64;
  localparam int unsigned AQED_LAT_W_DEFAULT      = 16;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ARMED     = 3'd1,
    S_WAIT_DONE = 3'd2,
    S_PASS      = 3'd3,
    S_FAIL      = 3'd4,
    S_TIMEOUT   = 3'd5
  } aqed_mon_state_t;

  function automatic logic is_busy(input aqed_mon_state_t s);
    return (s == S_ARMED) || (s == S_WAIT_DONE);
  endfunction

endpackage

// File: rtl/aqed_sat_counter.sv
// Saturating up-counter with synchronous clear; also exposes its incremented value
// so the caller can latch "count including this cycle" without a second adder.
module aqed_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic [W-1:0] cnt_inc_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         sat;

  assign sat       = &cnt_q;
  // Holding at all-ones keeps a runaway count from wrapping back under the bound.
  assign cnt_inc_o = sat ? cnt_q : cnt_q + W'(1);
  assign cnt_o     = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_inc_o;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/aqed_result_monitor.sv
// Sticky PASS/FAIL/TIMEOUT verdict for one A-QED original/duplicate pair, with a
// response bound and latency measured from the original issue.
module aqed_result_monitor
  import aqed_mon_pkg::*;
#(
  parameter int unsigned RESP_BOUND = AQED_RESP_BOUND_DEFAULT,
  parameter int unsigned LAT_W      = AQED_LAT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clk_en,
  input  logic             flush,
  input  logic             exec_dup,
  input  logic             wen_in,
  input  logic             valid_out,
  input  logic             qed_done,
  input  logic             qed_check,
  output logic             check_pass,
  output logic             check_fail,
  output logic             bound_fail,
  output logic             proto_err,
  output logic             busy,
  output logic [LAT_W-1:0] resp_latency
);

  // The bound test uses the pre-increment count, so compare against RESP_BOUND-1.
  localparam logic [LAT_W-1:0] BOUND_LAST = LAT_W'(RESP_BOUND - 1);

  aqed_mon_state_t  state_q, state_d;
  logic [LAT_W-1:0] cnt, cnt_inc;
  logic [LAT_W-1:0] resp_latency_q, resp_latency_d;
  logic             proto_err_q, proto_err_d;
  logic             iss, bound_hit, cnt_clr, cnt_en;
  logic             unused_valid_out;

  // valid_out carries no information beyond what qed_done already gives this stage.
  assign unused_valid_out = valid_out;

  assign iss       = clk_en & exec_dup & wen_in & ~flush;
  assign bound_hit = (cnt == BOUND_LAST);

  aqed_sat_counter #(
    .W (LAT_W)
  ) u_cnt (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr_i     (cnt_clr),
    .inc_i     (cnt_en),
    .cnt_o     (cnt),
    .cnt_inc_o (cnt_inc)
  );

  always_comb begin
    state_d        = state_q;
    proto_err_d    = proto_err_q;
    resp_latency_d = resp_latency_q;
    cnt_clr        = 1'b0;
    cnt_en         = 1'b0;
    if (clk_en) begin
      case (state_q)
        S_IDLE: begin
          if (qed_done) begin
            state_d     = S_FAIL;
            proto_err_d = 1'b1;
          end else if (iss) begin
            state_d = S_ARMED;
            cnt_clr = 1'b1;
          end
        end
        S_ARMED: begin
          cnt_en = 1'b1;
          if (qed_done) begin
            state_d     = S_FAIL;
            proto_err_d = 1'b1;
          end else if (bound_hit) begin
            state_d = S_TIMEOUT;
          end else if (iss) begin
            state_d = S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          cnt_en = 1'b1;
          if (qed_done) begin
            // Latency counts the edge that delivers done as well.
            resp_latency_d = cnt_inc;
            state_d        = qed_check ? S_PASS : S_FAIL;
          end else if (bound_hit) begin
            state_d = S_TIMEOUT;
          end
        end
        S_PASS: begin
          if (qed_done && !qed_check) begin
            state_d = S_FAIL;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      proto_err_q    <= 1'b0;
      resp_latency_q <= '0;
    end else begin
      state_q        <= state_d;
      proto_err_q    <= proto_err_d;
      resp_latency_q <= resp_latency_d;
    end
  end

  assign check_pass   = (state_q == S_PASS);
  assign check_fail   = (state_q == S_FAIL);
  assign bound_fail   = (state_q == S_TIMEOUT);
  assign busy         = is_busy(state_q);
  assign proto_err    = proto_err_q;
  assign resp_latency = resp_latency_q;

endmodule
